// File: rtl/iddmm_add_if.sv
// Bus bundle for the word-serial multi-precision adder: control handshake,
// operand-RAM read port and result-RAM write port.
interface iddmm_add_if #(
  parameter int K      = 128,
  parameter int ADDR_W = 5
);
  logic              start;
  logic              carry_in;
  logic              busy;
  logic              done;
  logic              carry_out;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [K-1:0]      a_rdata;
  logic [K-1:0]      b_rdata;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [K-1:0]      wr_data;

  modport slave (
    input  start, carry_in, a_rdata, b_rdata,
    output busy, done, carry_out, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );

  modport master (
    output start, carry_in, a_rdata, b_rdata,
    input  busy, done, carry_out, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/iddmm_add.sv
// Word-serial multi-precision adder R = A + B + carry_in over N words of K bits.
// Sequences operand reads, absorbs the 1-cycle RAM latency and streams sum words out.
module iddmm_add #(
  parameter int K      = 128,
  parameter int N      = 32,
  parameter int ADDR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic        clk,
  input  logic        rst_n,
  iddmm_add_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);

  state_t            r_state;
  logic              r_drain;
  logic              r_busy;
  logic              r_done;
  logic              r_carry_out;
  logic              r_carry;
  logic              r_rd_en;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_vld_p1;
  logic [ADDR_W-1:0] r_addr_p1;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [K-1:0]      r_wr_data;
  logic [K:0]        w_sum;

  // Data stage: operand words arriving this cycle plus the chained carry.
  assign w_sum = {1'b0, bus.a_rdata} + {1'b0, bus.b_rdata} + {{K{1'b0}}, r_carry};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_drain     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_carry_out <= 1'b0;
      r_carry     <= 1'b0;
      r_rd_en     <= 1'b0;
      r_rd_addr   <= '0;
      r_vld_p1    <= 1'b0;
      r_addr_p1   <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
    end else begin
      r_done    <= 1'b0;
      // Stage p1: read request delayed to line up with the returning RAM data.
      r_vld_p1  <= r_rd_en;
      r_addr_p1 <= r_rd_addr;
      // Stage p2: register the sum word and the carry into the next word.
      r_wr_en   <= r_vld_p1;
      if (r_vld_p1) begin
        r_wr_addr <= r_addr_p1;
        r_wr_data <= w_sum[K-1:0];
        r_carry   <= w_sum[K];
        if (r_addr_p1 == LAST) begin
          r_done      <= 1'b1;
          r_carry_out <= w_sum[K];
        end
      end

      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state     <= S_READ;
            r_busy      <= 1'b1;
            r_rd_en     <= 1'b1;
            r_rd_addr   <= '0;
            r_carry     <= bus.carry_in;
            r_carry_out <= 1'b0;
          end
        end
        S_READ: begin
          if (r_rd_addr == LAST) begin
            r_state   <= S_DRAIN;
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
            r_drain   <= 1'b0;
          end else begin
            r_rd_addr <= r_rd_addr + ADDR_W'(1);
          end
        end
        S_DRAIN: begin
          // Two cycles: one for the read-latency stage, one for the write stage.
          if (r_drain) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_drain <= 1'b0;
          end else begin
            r_drain <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_rd_en <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.carry_out = r_carry_out;
  assign bus.rd_en     = r_rd_en;
  assign bus.rd_addr   = r_rd_addr;
  assign bus.wr_en     = r_wr_en;
  assign bus.wr_addr   = r_wr_addr;
  assign bus.wr_data   = r_wr_data;

endmodule

// File: tb/tb_iddmm_add.sv
// Bench for iddmm_add: three instances (N=32, N=4, N=1, K=128) sharing one
// operand memory, a directed vector table, reset cases and random ops vs a big-integer model.
module tb_iddmm_add;

  localparam int K = 128;

  logic clk;
  logic rst_n;
  logic start;
  logic cin;
  int   sel;
  int   checks;
  int   errors;

  logic [K-1:0] memA [0:31];
  logic [K-1:0] memB [0:31];
  logic [K-1:0] exp_w [0:31];
  logic         exp_co;

  iddmm_add_if #(.K(K), .ADDR_W(5)) if32 ();
  iddmm_add_if #(.K(K), .ADDR_W(2)) if4 ();
  iddmm_add_if #(.K(K), .ADDR_W(1)) if1 ();

  iddmm_add #(.K(K), .N(32)) u32 (.clk(clk), .rst_n(rst_n), .bus(if32.slave));
  iddmm_add #(.K(K), .N(4))  u4  (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
  iddmm_add #(.K(K), .N(1))  u1  (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

  assign if32.start = start && (sel == 0);
  assign if4.start  = start && (sel == 1);
  assign if1.start  = start && (sel == 2);
  assign if32.carry_in = cin;
  assign if4.carry_in  = cin;
  assign if1.carry_in  = cin;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Operand RAMs: 1-cycle read latency, garbage on the bus when not read.
  always @(posedge clk) begin
    if (if32.rd_en) begin
      if32.a_rdata <= memA[if32.rd_addr];
      if32.b_rdata <= memB[if32.rd_addr];
    end else begin
      if32.a_rdata <= {$urandom, $urandom, $urandom, $urandom};
      if32.b_rdata <= {$urandom, $urandom, $urandom, $urandom};
    end
    if (if4.rd_en) begin
      if4.a_rdata <= memA[if4.rd_addr];
      if4.b_rdata <= memB[if4.rd_addr];
    end else begin
      if4.a_rdata <= {$urandom, $urandom, $urandom, $urandom};
      if4.b_rdata <= {$urandom, $urandom, $urandom, $urandom};
    end
    if (if1.rd_en) begin
      if1.a_rdata <= memA[if1.rd_addr];
      if1.b_rdata <= memB[if1.rd_addr];
    end else begin
      if1.a_rdata <= {$urandom, $urandom, $urandom, $urandom};
      if1.b_rdata <= {$urandom, $urandom, $urandom, $urandom};
    end
  end

  logic         m_busy, m_done, m_co, m_rd_en, m_wr_en;
  logic [K-1:0] m_rd_addr, m_wr_addr, m_wr_data;

  always_comb begin
    m_busy = if32.busy; m_done = if32.done; m_co = if32.carry_out;
    m_rd_en = if32.rd_en; m_wr_en = if32.wr_en; m_wr_data = if32.wr_data;
    m_rd_addr = K'(if32.rd_addr); m_wr_addr = K'(if32.wr_addr);
    if (sel == 1) begin
      m_busy = if4.busy; m_done = if4.done; m_co = if4.carry_out;
      m_rd_en = if4.rd_en; m_wr_en = if4.wr_en; m_wr_data = if4.wr_data;
      m_rd_addr = K'(if4.rd_addr); m_wr_addr = K'(if4.wr_addr);
    end else if (sel == 2) begin
      m_busy = if1.busy; m_done = if1.done; m_co = if1.carry_out;
      m_rd_en = if1.rd_en; m_wr_en = if1.wr_en; m_wr_data = if1.wr_data;
      m_rd_addr = K'(if1.rd_addr); m_wr_addr = K'(if1.wr_addr);
    end
  end

  function automatic int words_of(input int s);
    return (s == 0) ? 32 : (s == 1) ? 4 : 1;
  endfunction

  task automatic chk(input string nm, input logic [K-1:0] act, input logic [K-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_idle(input string nm);
    chk({nm, " busy"},      K'(m_busy),  '0);
    chk({nm, " done"},      K'(m_done),  '0);
    chk({nm, " carry_out"}, K'(m_co),    '0);
    chk({nm, " rd_en"},     K'(m_rd_en), '0);
    chk({nm, " rd_addr"},   m_rd_addr,   '0);
    chk({nm, " wr_en"},     K'(m_wr_en), '0);
    chk({nm, " wr_addr"},   m_wr_addr,   '0);
    chk({nm, " wr_data"},   m_wr_data,   '0);
  endtask

  // Golden model: one wide integer addition over the first n words.
  task automatic model(input int n, input bit c);
    logic [4095:0] ba, bb;
    logic [4096:0] br;
    ba = '0;
    bb = '0;
    for (int i = 0; i < n; i++) begin
      ba[K*i +: K] = memA[i];
      bb[K*i +: K] = memB[i];
    end
    br = {1'b0, ba} + {1'b0, bb} + 4097'(c);
    for (int i = 0; i < 32; i++) exp_w[i] = (i < n) ? br[K*i +: K] : '0;
    exp_co = br[K*n];
  endtask

  // Issues start now; checks every output cycle by cycle through cycle n+3,
  // and returns positioned at the falling edge of cycle n+3 (FSM idle).
  task automatic run_op(input int s, input bit c, input int stray, input string tag);
    int n;
    n     = words_of(s);
    sel   = s;
    start = 1'b1;
    cin   = c;
    @(posedge clk); #1;
    start = 1'b0;
    cin   = ~c;
    for (int rel = 1; rel <= n + 3; rel++) begin
      if (rel == stray) start = 1'b1;
      @(negedge clk);
      chk($sformatf("%s busy c%0d", tag, rel),  K'(m_busy),  K'(rel <= n + 2));
      chk($sformatf("%s rd_en c%0d", tag, rel), K'(m_rd_en), K'(rel <= n));
      if (rel <= n)
        chk($sformatf("%s rd_addr c%0d", tag, rel), m_rd_addr, K'(rel - 1));
      if (rel == n + 3)
        chk($sformatf("%s rd_addr idle", tag), m_rd_addr, '0);
      chk($sformatf("%s wr_en c%0d", tag, rel), K'(m_wr_en), K'(rel >= 3 && rel <= n + 2));
      if (rel >= 3 && rel <= n + 2) begin
        chk($sformatf("%s wr_addr c%0d", tag, rel), m_wr_addr, K'(rel - 3));
        chk($sformatf("%s wr_data w%0d", tag, rel - 3), m_wr_data, exp_w[rel - 3]);
      end
      chk($sformatf("%s done c%0d", tag, rel), K'(m_done), K'(rel == n + 2));
      if (rel == 1 || rel >= n + 2)
        chk($sformatf("%s carry_out c%0d", tag, rel), K'(m_co), (rel == 1) ? '0 : K'(exp_co));
      if (rel < n + 3) begin
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
  endtask

  typedef struct {
    int           s;
    logic [K-1:0] a;
    logic [K-1:0] b0;
    logic [K-1:0] br;
    bit           c;
    int           stray;
    bit           b2b;
    logic [K-1:0] w0;
    logic [K-1:0] wr;
    bit           co;
  } vec_t;

  vec_t tbl [7];

  initial begin
    logic [K-1:0] ones, msb, h5, ha;
    ones = '1;
    msb  = {1'b1, {(K-1){1'b0}}};
    h5   = {(K/4){4'h5}};
    ha   = {(K/4){4'hA}};
    tbl[0] = '{1, ones, 1,   0,  1'b0, 0, 1'b0, 0,    0,    1'b1};
    tbl[1] = '{1, 0,    0,   0,  1'b1, 3, 1'b0, 1,    0,    1'b0};
    tbl[2] = '{1, ones, 0,   0,  1'b1, 0, 1'b1, 0,    0,    1'b1};
    tbl[3] = '{2, msb,  msb, 0,  1'b1, 0, 1'b0, 1,    0,    1'b1};
    tbl[4] = '{2, ones, 0,   0,  1'b0, 2, 1'b0, ones, 0,    1'b0};
    tbl[5] = '{1, h5,   ha,  ha, 1'b0, 0, 1'b0, ones, ones, 1'b0};
    tbl[6] = '{1, h5,   ha,  ha, 1'b1, 5, 1'b1, 0,    0,    1'b1};

    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    cin    = 1'b0;
    sel    = 0;
    for (int i = 0; i < 32; i++) begin
      memA[i] = '0;
      memB[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset then idle with start low.
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      for (int s = 0; s < 3; s++) begin
        sel = s;
        #1;
        check_idle($sformatf("idle s%0d c%0d", s, cyc));
      end
    end
    @(posedge clk); #1;

    // Directed vectors.
    for (int v = 0; v < 7; v++) begin
      if (!tbl[v].b2b) begin
        repeat (2) @(posedge clk);
        #1;
      end
      for (int i = 0; i < 32; i++) begin
        memA[i] = tbl[v].a;
        memB[i] = (i == 0) ? tbl[v].b0 : tbl[v].br;
      end
      for (int i = 0; i < 32; i++) exp_w[i] = (i == 0) ? tbl[v].w0 : tbl[v].wr;
      exp_co = tbl[v].co;
      run_op(tbl[v].s, tbl[v].c, tbl[v].stray, $sformatf("vec%0d", v));
    end

    // Reset asserted in cycle 3 of an N=4 operation.
    @(posedge clk); #1;
    for (int i = 0; i < 32; i++) begin
      memA[i] = {$urandom, $urandom, $urandom, $urandom};
      memB[i] = {$urandom, $urandom, $urandom, $urandom};
    end
    sel   = 1;
    start = 1'b1;
    cin   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_idle("in reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      chk($sformatf("post-rst wr_en c%0d", cyc), K'(m_wr_en), '0);
      chk($sformatf("post-rst done c%0d", cyc),  K'(m_done),  '0);
      chk($sformatf("post-rst rd_en c%0d", cyc), K'(m_rd_en), '0);
      chk($sformatf("post-rst busy c%0d", cyc),  K'(m_busy),  '0);
    end
    @(posedge clk); #1;
    model(4, 1'b0);
    run_op(1, 1'b0, 0, "after-rst");

    // Randomised operations on the full-size instance.
    for (int t = 0; t < 100; t++) begin
      bit c;
      int stray;
      if ($urandom_range(0, 2) != 0) begin
        @(posedge clk); #1;
      end
      for (int i = 0; i < 32; i++) begin
        case ($urandom_range(0, 3))
          0:       begin memA[i] = '1; memB[i] = {$urandom, $urandom, $urandom, $urandom}; end
          1:       begin memA[i] = {$urandom, $urandom, $urandom, $urandom}; memB[i] = ~memA[i]; end
          default: begin
            memA[i] = {$urandom, $urandom, $urandom, $urandom};
            memB[i] = {$urandom, $urandom, $urandom, $urandom};
          end
        endcase
      end
      c     = 1'($urandom_range(0, 1));
      stray = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 34) : 0;
      model(32, c);
      run_op(0, c, stray, $sformatf("rnd%0d", t));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/iddmm_add.md
Name: iddmm_add

Overview:
- Word-serial multi-precision adder: computes R = A + B + carry_in over N words of K bits, plus a final carry_out.
- It is the addition counterpart to the word-serial subtractor in the Montgomery datapath, used for the IDDMM accumulate and correction steps.
- Unlike the subtractor, it owns its sequencing. It drives the operand-RAM read addresses, absorbs the 1-cycle RAM read latency, and streams sum words into a result RAM.
- It signals completion with a done pulse.

Parameters:
- K, 128, word width in bits.
- N, 32, number of words per operand (N >= 1).
- ADDR_W, $clog2(N) (minimum 1), word address width.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin an operation; sampled only in IDLE.
- carry_in  input  1  initial carry into word 0; sampled with start.
- busy  output  1  high while an operation is in flight.
- done  output  1  single-cycle pulse coincident with the last result write.
- carry_out  output  1  final carry of the most recent operation; held until the next start is accepted.
- rd_en  output  1  operand RAM read enable.
- rd_addr  output  ADDR_W  operand word address, shared by the A and B RAMs.
- a_rdata  input  K  A word; valid exactly 1 cycle after rd_en.
- b_rdata  input  K  B word; valid exactly 1 cycle after rd_en.
- wr_en  output  1  result RAM write enable.
- wr_addr  output  ADDR_W  result word address.
- wr_data  output  K  result word.

Behaviour:
- Reset: asynchronous on rst_n low. All outputs are 0: busy, done, carry_out, rd_en, rd_addr, wr_en, wr_addr, wr_data. FSM goes to IDLE and the internal carry register clears.
- Reset mid-operation: the operation is aborted. No further rd_en or wr_en is issued after reset deasserts, and no done pulse is produced.
- FSM states: IDLE, READ, DRAIN.
  - IDLE to READ: on start=1. The internal carry register loads carry_in; carry_out clears to 0.
  - READ: rd_en=1, with rd_addr stepping 0,1,...,N-1 on consecutive cycles. On the cycle rd_addr=N-1, the next state is DRAIN.
  - DRAIN: rd_en=0. Lasts 2 cycles so the last word can pass the read-latency stage and the write stage. Then return to IDLE.
- Timing: start sampled high at the edge ending cycle 0 gives the following.
  - rd_en=1 with rd_addr=i in cycle 1+i.
  - Data for word i arrives in cycle 2+i.
  - wr_en=1 with wr_addr=i and wr_data=sum_i in cycle 3+i.
  - The last write is in cycle N+2. done=1 only in cycle N+2.
  - busy=1 in cycles 1 through N+2 inclusive, and 0 in cycle N+3, where the FSM is in IDLE.
- Arithmetic: in the data cycle of word i, s = {1'b0,a_rdata} + {1'b0,b_rdata} + c, a (K+1)-bit value.
  - wr_data is registered as s[K-1:0].
  - c is registered as s[K], so the carry chains across words with no bubbles.
  - c is used only for words 0..N-1. carry_out is registered as s[K] of word N-1 and becomes valid in cycle N+2, together with done.
- Pipeline: a delayed copy of rd_en/rd_addr (valid_d1, addr_d1) qualifies the incoming data. wr_en and wr_addr are registered from valid_d1 and addr_d1. wr_en is 0 outside write cycles. wr_data holds its last value when wr_en=0.
- start while busy=1 (READ or DRAIN) is ignored and carry_in is not sampled.
- start in cycle N+3 (IDLE) is accepted. The minimum issue interval is therefore N+3 cycles.
- N=1: rd_addr=0 in cycle 1 only; the single write and done both occur in cycle 3.
- rd_addr wraps only through FSM control; it is never driven beyond N-1. rd_addr holds 0 in IDLE.

Test Plan:
- Reset then idle, 20 cycles with start=0 -> all outputs remain 0, and no rd_en or wr_en appears.
- N=4, A words all 0xFFFF...F, B word0=1 and other B words=0, carry_in=0 -> wr_data for all 4 words=0, carry_out=1, done in cycle 6, rd_en high in cycles 1-4 and wr_en high in cycles 3-6.
- N=4, A=B=0, carry_in=1 -> word0=1, words1-3=0, carry_out=0. Then a back-to-back start in cycle 7 is accepted, while start in cycle 3 is ignored.
- Randomised 100 operations with default K/N against a golden 4096-bit adder -> every result word and carry_out match, and wr_addr is sequential 0..N-1.
- Assert rst_n low in cycle 3 of an N=4 operation, release it, and hold start=0 -> no write or done after release. Then a new operation completes correctly.
- N=1, A=0x8000...0, B=0x8000...0, carry_in=1 -> wr_data=1, carry_out=1, done and wr_en both in cycle 3.
